// File: rtl/tff_ctrl_pkg.sv
// Shared types and constants for the T-flip-flop counter controller.
package tff_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/tff_counter_ctrl_cell.sv
// Single T flip-flop: q toggles on a rising clock edge when t is high.
module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  // Toggle storage with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= 1'b0;
    else if (t) q <= ~q;
  end

endmodule

// File: rtl/tff_counter_ctrl.sv
// Timer/tick engine: a WIDTH-bit counter built from T flip-flop cells, with
// start/stop/hold control, one-shot or periodic terminal-count handling.
// Optional macro TFF_CTRL_UPDOWN_EN adds a 'down' input for down-counting.
module tff_counter_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             mode,
`ifdef TFF_CTRL_UPDOWN_EN
  input  logic             down,
`endif
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] limit_q;
  logic             mode_q;
  logic             down_q;
  logic             down_in;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] inc_t, dec_t;
  logic             latch;
  logic             done_d, wrap_d;
  logic             at_term;

`ifdef TFF_CTRL_UPDOWN_EN
  assign down_in = down;
`else
  assign down_in = 1'b0;
`endif

  // Per-bit toggle enables for increment (all lower bits 1) and decrement (all lower bits 0).
  always_comb begin
    inc_t = '0;
    dec_t = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      logic all_one, all_zero;
      all_one  = 1'b1;
      all_zero = 1'b1;
      for (int unsigned j = 0; j < i; j++) begin
        all_one  = all_one & count[j];
        all_zero = all_zero & ~count[j];
      end
      inc_t[i] = all_one;
      dec_t[i] = all_zero;
    end
  end

  assign at_term = down_q ? (count == '0) : (count == limit_q);

  // Next state and toggle-enable mux; clears toggle the set bits, loads toggle the differing bits.
  always_comb begin
    state_d = state_q;
    t       = '0;
    latch   = 1'b0;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (stop) begin
          t = count;
        end else if (start) begin
          latch   = 1'b1;
          t       = down_in ? (count ^ limit) : count;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          t       = count;
          state_d = ST_IDLE;
        end else if (!hold) begin
          if (at_term) begin
            if (mode_q == MODE_PERIODIC) begin
              t      = down_q ? (count ^ limit_q) : count;
              wrap_d = 1'b1;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            t = down_q ? dec_t : inc_t;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (stop) t = count;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched configuration and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      limit_q <= '0;
      mode_q  <= MODE_ONESHOT;
      down_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        limit_q <= limit;
        mode_q  <= mode;
        down_q  <= down_in;
      end
      busy <= (state_d == ST_RUN);
      done <= done_d;
      wrap <= wrap_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .t     (t[i]),
      .q     (count[i])
    );
  end

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Self-checking bench for tff_counter_ctrl (WIDTH=8): directed scenarios plus
// randomized control traffic checked against a behavioural timer model.
module tb_tff_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, hold, mode, down;
  logic [7:0] limit;
  logic [7:0] count;
  logic       busy, done, wrap;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model: running flag, one-cycle done phase, integer counter value.
  bit m_run, m_in_done, m_per, m_dn;
  int m_cnt, m_lim;
  bit exp_done, exp_wrap;

  tff_counter_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .hold  (hold),
    .mode  (mode),
`ifdef TFF_CTRL_UPDOWN_EN
    .down  (down),
`endif
    .limit (limit),
    .count (count),
    .busy  (busy),
    .done  (done),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_in_done = 0; m_per = 0; m_dn = 0;
    m_cnt = 0; m_lim = 0; exp_done = 0; exp_wrap = 0;
  endtask

  // Advance the model by one clock using the inputs that were present at the edge.
  task automatic model_step(input bit s, input bit p, input bit h, input bit md,
                            input int lm, input bit dn);
    bit term;
    exp_done = 0;
    exp_wrap = 0;
    if (p) begin
      m_cnt = 0; m_run = 0; m_in_done = 0;
    end else if (m_run) begin
      if (!h) begin
        term = m_dn ? (m_cnt == 0) : (m_cnt == m_lim);
        if (term && m_per) begin
          m_cnt = m_dn ? m_lim : 0;
          exp_wrap = 1;
        end else if (term) begin
          m_run = 0; m_in_done = 1; exp_done = 1;
        end else begin
          m_cnt = m_dn ? m_cnt - 1 : m_cnt + 1;
        end
      end
    end else if (m_in_done) begin
      m_in_done = 0;
    end else if (s) begin
      m_lim = lm; m_per = md; m_dn = dn;
      m_cnt = dn ? lm : 0;
      m_run = 1;
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare all outputs with the model.
  task automatic step(input bit s, input bit p, input bit h, input bit md,
                      input logic [7:0] lm, input bit dn);
    bit dn_eff;
`ifdef TFF_CTRL_UPDOWN_EN
    dn_eff = dn;
`else
    dn_eff = 1'b0;
`endif
    start = s; stop = p; hold = h; mode = md; limit = lm; down = dn;
    @(posedge clk);
    model_step(s, p, h, md, int'(lm), dn_eff);
    #1;
    chk("count", {24'd0, count}, m_cnt);
    chk("busy", {31'd0, busy}, {31'd0, m_run});
    chk("done", {31'd0, done}, {31'd0, exp_done});
    chk("wrap", {31'd0, wrap}, {31'd0, exp_wrap});
  endtask

  task automatic idle(input logic [7:0] lm);
    step(1'b0, 1'b0, 1'b0, 1'b0, lm, 1'b0);
  endtask

  initial begin
    model_reset();
    reset = 1'b1; start = 0; stop = 0; hold = 0; mode = 0; down = 0; limit = '0;
    #12;
    chk("rst_count", {24'd0, count}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_wrap", {31'd0, wrap}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // One-shot, limit 5.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0);
    chk("t1_start", {24'd0, count}, 0);
    for (int k = 1; k <= 5; k++) begin
      idle(8'd5);
      chk("t1_cnt", {24'd0, count}, k);
    end
    idle(8'd5);
    chk("t1_done", {31'd0, done}, 1);
    chk("t1_busy", {31'd0, busy}, 0);
    chk("t1_hold5", {24'd0, count}, 5);
    idle(8'd5);
    chk("t1_pulse", {31'd0, done}, 0);
    chk("t1_keep5", {24'd0, count}, 5);

    // Periodic, limit 3.
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      idle(8'd3);
      chk("t2_cnt", {24'd0, count}, k % 4);
      chk("t2_wrap", {31'd0, wrap}, (k % 4 == 0) ? 1 : 0);
      chk("t2_nodone", {31'd0, done}, 0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0);

    // limit 0 and limit 255 one-shots.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    idle(8'd0);
    chk("t3_l0_done", {31'd0, done}, 1);
    idle(8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd255, 1'b0);
    for (int k = 1; k <= 255; k++) idle(8'd0);
    chk("t3_max", {24'd0, count}, 255);
    idle(8'd0);
    chk("t3_max_done", {31'd0, done}, 1);
    chk("t3_no_ovf", {24'd0, count}, 255);
    idle(8'd0);

    // Hold at 3 for 4 cycles, then stop together with start.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd10, 1'b0);
    for (int k = 1; k <= 3; k++) idle(8'd10);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'd10, 1'b0);
      chk("t4_frozen", {24'd0, count}, 3);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'd10, 1'b0);
    chk("t4_clr", {24'd0, count}, 0);
    chk("t4_idle", {31'd0, busy}, 0);
    chk("t4_nodone", {31'd0, done}, 0);

    // Asynchronous reset between edges.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd9, 1'b0);
    idle(8'd9); idle(8'd9);
    #2 reset = 1'b1;
    #1;
    chk("t5_count", {24'd0, count}, 0);
    chk("t5_busy", {31'd0, busy}, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0);
    idle(8'd2); idle(8'd2); idle(8'd2);
    chk("t5_rerun", {31'd0, done}, 1);
    idle(8'd2);

`ifdef TFF_CTRL_UPDOWN_EN
    // Down-count periodic, limit 4: 4,3,2,1,0,4,...
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd4, 1'b1);
    chk("t6_load", {24'd0, count}, 4);
    for (int k = 1; k <= 10; k++) begin
      idle(8'd4);
      chk("t6_cnt", {24'd0, count}, 4 - (k % 5));
      chk("t6_wrap", {31'd0, wrap}, (k % 5 == 0) ? 1 : 0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
`endif

    // Randomized control traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] lm;
      lm = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 40) == 0),
           1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 1)), lm,
           1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
